// File: rtl/arch_dump_pkg.sv
// Shared types and constants for the architectural state dumper.
package arch_dump_pkg;

    localparam int XLEN    = 64;
    localparam int NREGS   = 32;
    localparam int RADDR_W = $clog2(NREGS);

    typedef logic [7:0] tag_t;

    localparam tag_t TAG_PC       = 8'd0;
    localparam tag_t TAG_PRV      = 8'd1;
    localparam tag_t TAG_XPR_BASE = 8'd2;
    localparam int   NUM_RECORDS  = 34;
    localparam tag_t TAG_LAST     = tag_t'(NUM_RECORDS - 1);

    typedef enum logic [2:0] {IDLE, HALT, SNAP, SEND, READ, WAIT, DONE} state_t;

    typedef struct packed {
        tag_t            tag;
        logic [XLEN-1:0] data;
        logic            last;
    } record_t;

endpackage

// File: rtl/arch_dump_if.sv
// Tagged record stream from the dumper to the harness sink.
interface arch_dump_if;
    import arch_dump_pkg::*;

    logic            out_valid;
    logic            out_ready;
    tag_t            out_tag;
    logic [XLEN-1:0] out_data;
    logic            out_last;

    modport master (output out_valid, out_tag, out_data, out_last, input out_ready);
    modport slave  (input out_valid, out_tag, out_data, out_last, output out_ready);
endinterface

// File: rtl/arch_dump_out_reg.sv
// Single-entry output holding register: loads one record, holds it until the sink takes it.
module arch_dump_out_reg
    import arch_dump_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  record_t     load_rec,
    output logic        fire,
    arch_dump_if.master dump
);

    assign fire = dump.out_valid && dump.out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the payload is reset as well, not just the valid bit, so every output reads 0 out of reset.
            dump.out_valid <= 1'b0;
            dump.out_tag   <= '0;
            dump.out_data  <= '0;
            dump.out_last  <= 1'b0;
        end else if (load) begin
            dump.out_valid <= 1'b1;
            dump.out_tag   <= load_rec.tag;
            dump.out_data  <= load_rec.data;
            dump.out_last  <= load_rec.last;
        end else if (fire) begin
            dump.out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/arch_state_dumper.sv
// Halts the core at an instruction boundary, snapshots PC/PRV, reads x0..x31 and streams
// 34 tagged records to the harness sink.
module arch_state_dumper
    import arch_dump_pkg::*;
#(
    parameter int RF_LATENCY = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [63:0]        cfg_dump_cycle,
    input  logic               trigger,
    input  logic               core_retire,
    input  logic [XLEN-1:0]    core_pc,
    input  logic [1:0]         core_prv,
    output logic               core_halt_req,
    input  logic               core_halted,
    output logic               rf_ren,
    output logic [RADDR_W-1:0] rf_raddr,
    input  logic [XLEN-1:0]    rf_rdata,
    arch_dump_if.master        dump,
    output logic               busy,
    output logic               done,
    output logic [63:0]        cycle_count
);

    localparam logic [1:0] LAT_INIT = 2'(RF_LATENCY - 1);

    state_t     state;
    tag_t       idx;
    logic [1:0] lat_cnt;
    logic       armed;
    logic       at_boundary;
    logic [1:0] prv_q;
    logic       auto_hit;
    logic       fire;
    logic       load;
    record_t    load_rec;

    assign auto_hit = armed && (cfg_dump_cycle != '0) && (cycle_count == cfg_dump_cycle);
    assign busy     = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            lat_cnt       <= '0;
            armed         <= 1'b1;
            at_boundary   <= 1'b0;
            prv_q         <= '0;
            cycle_count   <= '0;
            core_halt_req <= 1'b0;
            rf_ren        <= 1'b0;
            rf_raddr      <= '0;
            done          <= 1'b0;
        end else begin
            // NOTE: all state here uses <= so every branch sees the pre-edge values of its peers.
            cycle_count <= cycle_count + 64'd1;
            done        <= 1'b0;
            rf_ren      <= 1'b0;
            case (state)
                IDLE: if (trigger || auto_hit) begin
                    state         <= HALT;
                    core_halt_req <= 1'b1;
                    at_boundary   <= core_halted;
                    if (auto_hit) armed <= 1'b0;
                end
                // A core that was already halted is at a boundary; otherwise wait for a retire.
                HALT: begin
                    if (core_retire) at_boundary <= 1'b1;
                    if (core_halted && (at_boundary || core_retire)) state <= SNAP;
                end
                SNAP: begin
                    prv_q <= core_prv;
                    idx   <= TAG_PC;
                    state <= SEND;
                end
                SEND: if (fire) begin
                    if (idx == TAG_LAST) begin
                        state         <= DONE;
                        core_halt_req <= 1'b0;
                        done          <= 1'b1;
                    end else if (idx == TAG_PC) begin
                        idx <= TAG_PRV;
                    end else begin
                        rf_ren   <= 1'b1;
                        rf_raddr <= RADDR_W'(idx - 8'd1);
                        idx      <= idx + 8'd1;
                        state    <= READ;
                    end
                end
                READ: begin
                    lat_cnt <= LAT_INIT;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == 2'd0) state <= SEND;
                    else lat_cnt <= lat_cnt - 2'd1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Records are built here and registered by the holding register on the same edge.
    always_comb begin
        // NOTE: defaults first so no path leaves load/load_rec unassigned and infers a latch.
        load     = 1'b0;
        load_rec = '0;
        case (state)
            SNAP: begin
                load     = 1'b1;
                load_rec = '{tag: TAG_PC, data: core_pc, last: 1'b0};
            end
            SEND: if (fire && idx == TAG_PC) begin
                load     = 1'b1;
                load_rec = '{tag: TAG_PRV, data: XLEN'(prv_q), last: 1'b0};
            end
            WAIT: if (lat_cnt == 2'd0) begin
                load     = 1'b1;
                load_rec = '{tag: idx,
                             data: (idx == TAG_XPR_BASE) ? '0 : rf_rdata,
                             last: (idx == TAG_LAST)};
            end
            default: ;
        endcase
    end

    arch_dump_out_reg u_out_reg (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .load_rec (load_rec),
        .fire     (fire),
        .dump     (dump)
    );

endmodule
